// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte-stream feeder, its core and benches.
package aes_pkg;

    localparam int AES_BLK_BYTES = 16;
    localparam int AES_BLK_W     = 128;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/aes_byte_packer.sv
// Packs accepted bytes MSB-first into a 128-bit block and flags the byte
// that completes the block.
module aes_byte_packer
    import aes_pkg::*;
(
    input  logic                 clk,
    input  logic [7:0]           byte_in,
    input  logic                 accept,
    input  logic                 clear,
    output logic [AES_BLK_W-1:0] blk,
    output logic                 full
);

    localparam int CNT_W = $clog2(AES_BLK_BYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_BLK_BYTES - 1);

    logic [AES_BLK_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        full    = 1'b0;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            shift_d = {shift_q[AES_BLK_W-9:0], byte_in};
            cnt_d   = cnt_q + CNT_W'(1);
            full    = (cnt_q == CNT_LAST);
        end
    end

    // The block includes the byte being accepted, so it is complete on the full strobe.
    assign blk = shift_d;

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
    end

endmodule

// File: rtl/aes_stream_feeder.sv
// Collects a byte stream into 128-bit blocks, hands each block to an AES core
// and presents the ciphertext on a valid/ready port, with a per-block timeout.
//
// state   | meaning
// S_FILL  | accepting plaintext bytes (in_ready=1)
// S_ISSUE | one-cycle aes_start pulse
// S_WAIT  | waiting for aes_done, timeout counter running
// S_HOLD  | ciphertext presented until out_ready
module aes_stream_feeder
    import aes_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] key_in,
    output logic [AES_BLK_W-1:0] aes_plaintext,
    output logic [AES_BLK_W-1:0] aes_key,
    output logic                 aes_start,
    input  logic                 aes_done,
    input  logic [AES_BLK_W-1:0] aes_ciphertext,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [11:0]          blk_count,
    output logic                 err
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    feeder_state_e        state_q, state_d;
    logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [AES_BLK_W-1:0] pt_q, pt_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] out_data_q, out_data_d;
    logic [11:0]          blk_count_q, blk_count_d;
    logic                 err_q, err_d;

    logic                 accept;
    logic                 pk_full;
    logic [AES_BLK_W-1:0] pk_blk;
    logic                 wait_expired;

    assign accept       = in_valid & in_ready;
    assign wait_expired = (state_q == S_WAIT) && !aes_done && (wait_cnt_q == WAIT_LAST);

    aes_byte_packer u_packer (
        .clk     (clk),
        .byte_in (in_data),
        .accept  (accept),
        .clear   (!rst),
        .blk     (pk_blk),
        .full    (pk_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (pk_full) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (aes_done) begin
                    state_d = S_HOLD;
                end else if (wait_expired) begin
                    state_d = S_FILL;
                end
            end
            S_HOLD:  if (out_ready) state_d = S_FILL;
            default: state_d = S_FILL;
        endcase
    end

    always_comb begin
        in_ready  = rst && (state_q == S_FILL);
        aes_start = (state_q == S_ISSUE);
        out_valid = (state_q == S_HOLD);
    end

    always_comb begin
        pt_d        = pt_q;
        key_d       = key_q;
        out_data_d  = out_data_q;
        blk_count_d = blk_count_q;
        err_d       = err_q;
        wait_cnt_d  = '0;
        if (pk_full) begin
            pt_d  = pk_blk;
            key_d = key_in;
        end
        if (state_q == S_WAIT && !aes_done && !wait_expired) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        // aes_done takes priority over a coincident timeout.
        if (state_q == S_WAIT && aes_done) begin
            out_data_d = aes_ciphertext;
        end
        if (wait_expired) begin
            err_d = 1'b1;
        end
        if (state_q == S_HOLD && out_ready) begin
            blk_count_d = blk_count_q + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt_q  <= '0;
            pt_q        <= '0;
            key_q       <= '0;
            out_data_q  <= '0;
            blk_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            pt_q        <= pt_d;
            key_q       <= key_d;
            out_data_q  <= out_data_d;
            blk_count_q <= blk_count_d;
            err_q       <= err_d;
        end
    end

    assign aes_plaintext = pt_q;
    assign aes_key       = key_q;
    assign out_data      = out_data_q;
    assign blk_count     = blk_count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_aes_stream_feeder.sv
// Scoreboard bench for aes_stream_feeder with a behavioural AES core stand-in.
module tb_aes_stream_feeder;
    import aes_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [AES_BLK_W-1:0] key_in;
    logic [AES_BLK_W-1:0] aes_plaintext;
    logic [AES_BLK_W-1:0] aes_key;
    logic                 aes_start;
    logic                 aes_done;
    logic [AES_BLK_W-1:0] aes_ciphertext;
    logic [AES_BLK_W-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [11:0]          blk_count;
    logic                 err;

    always #5 clk = ~clk;

    aes_stream_feeder #(.TIMEOUT(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .key_in         (key_in),
        .aes_plaintext  (aes_plaintext),
        .aes_key        (aes_key),
        .aes_start      (aes_start),
        .aes_done       (aes_done),
        .aes_ciphertext (aes_ciphertext),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .blk_count      (blk_count),
        .err            (err)
    );

    typedef struct {
        logic [127:0] ct;
        logic [11:0]  cnt;
    } exp_t;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1 = 128'h4920616d206120706c61696e74657874;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] P3 = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] P4 = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] P5 = 128'h5555aaaa5555aaaa3333cccc3333cccc;
    localparam logic [127:0] P6 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] P7 = 128'h8899aabbccddeeff0011223344556677;

    int           n_vec = 0;
    int           n_err = 0;
    exp_t         sb_q[$];
    logic [11:0]  exp_blk = '0;
    int           lat = 1;
    bit           spur_req = 1'b0;
    int           start_cnt = 0;
    logic [127:0] m_pt, m_key;
    logic [127:0] mon_prev;
    bit           mon_have_prev = 1'b0;
    bit           mon_pend = 1'b0;
    bit           mon_prev_start = 1'b0;
    logic [11:0]  mon_pend_cnt;
    exp_t         mon_e;

    function automatic logic [127:0] fake_aes(input logic [127:0] pt, input logic [127:0] k);
        return {pt[63:0], pt[127:64]} ^ k ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_blk(input logic [127:0] pt, input logic [127:0] k);
        exp_t e;
        exp_blk = exp_blk + 12'd1;
        e.ct    = fake_aes(pt, k);
        e.cnt   = exp_blk;
        sb_q.push_back(e);
    endtask

    // Drives bytes first..first+n-1 of pt, one per cycle, once in_ready is seen.
    task automatic send_bytes(input logic [127:0] pt, input int first, input int n);
        int t;
        @(negedge clk);
        t = 0;
        while (!in_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_wait_in_ready: in_ready stayed %0b, expected 1", in_ready);
        end else begin
            for (int i = first; i < first + n; i++) begin
                in_data  = pt[127-8*i -: 8];
                in_valid = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_ready(input string name);
        int t;
        t = 0;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, in_ready, 1);
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!out_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk(name, out_valid, 1);
    endtask

    // Core stand-in: answers lat cycles after a start, or never when lat <= 0.
    initial begin
        aes_done       = 1'b0;
        aes_ciphertext = '0;
        forever begin
            @(negedge clk);
            if (spur_req) begin
                aes_done       = 1'b1;
                aes_ciphertext = '1;
                @(negedge clk);
                aes_done = 1'b0;
                spur_req = 1'b0;
            end else if (aes_start && lat > 0) begin
                m_pt  = aes_plaintext;
                m_key = aes_key;
                repeat (lat) @(negedge clk);
                aes_done       = 1'b1;
                aes_ciphertext = fake_aes(m_pt, m_key);
                @(negedge clk);
                aes_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                mon_have_prev  = 1'b0;
                mon_pend       = 1'b0;
                mon_prev_start = 1'b0;
            end else begin
                if (mon_pend) begin
                    chk("blk_count_after_handshake", blk_count, mon_pend_cnt);
                    mon_pend = 1'b0;
                end
                if (aes_start) begin
                    start_cnt++;
                    chk("aes_start_single_cycle", mon_prev_start, 0);
                end
                mon_prev_start = aes_start;
                if (out_valid) begin
                    chk("in_ready_while_out_valid", in_ready, 0);
                    if (mon_have_prev) chk("out_data_stable", out_data, mon_prev);
                    mon_prev      = out_data;
                    mon_have_prev = 1'b1;
                    if (out_ready) begin
                        if (sb_q.size() == 0) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_out_valid: out_data %0h, no block expected", out_data);
                        end else begin
                            mon_e = sb_q.pop_front();
                            chk("out_data", out_data, mon_e.ct);
                            mon_pend     = 1'b1;
                            mon_pend_cnt = mon_e.cnt;
                        end
                        mon_have_prev = 1'b0;
                    end
                end else begin
                    mon_have_prev = 1'b0;
                end
            end
        end
    end

    initial begin
        int starts;
        logic [31:0] w;
        logic [127:0] pt;
        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        key_in    = K1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_aes_start", aes_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_aes_plaintext", aes_plaintext, 0);
        chk("rst_aes_key", aes_key, 0);
        chk("rst_blk_count", blk_count, 0);
        chk("rst_err", err, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Known-answer block with slow core and back-pressure.
        lat       = 30;
        out_ready = 1'b0;
        expect_blk(P1, K1);
        send_bytes(P1, 0, 16);
        chk("issue_aes_start", aes_start, 1);
        chk("issue_plaintext", aes_plaintext, 128'h4920616d206120706c61696e74657874);
        chk("issue_key", aes_key, K1);
        chk("issue_in_ready", in_ready, 0);
        @(negedge clk);
        chk("wait_aes_start_low", aes_start, 0);
        chk("wait_plaintext_stable", aes_plaintext, 128'h4920616d206120706c61696e74657874);
        wait_valid("slow_core_out_valid");
        for (int i = 0; i < 5; i++) begin
            chk("hold_out_data", out_data, fake_aes(P1, K1));
            chk("hold_in_ready", in_ready, 0);
            chk("hold_blk_count", blk_count, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("blk_count_first", blk_count, 1);
        chk("start_count_first", start_cnt, 1);

        // Spurious aes_done while filling is ignored.
        lat = 1;
        expect_blk(P2, K1);
        send_bytes(P2, 0, 8);
        spur_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("spur_in_ready", in_ready, 1);
        chk("spur_out_valid", out_valid, 0);
        chk("spur_aes_start", aes_start, 0);
        send_bytes(P2, 8, 8);
        @(negedge clk);
        wait_ready("spur_block_done");

        // aes_done on the timeout-expiry cycle wins.
        key_in = K2;
        lat    = 64;
        expect_blk(P3, K2);
        send_bytes(P3, 0, 16);
        repeat (64) @(negedge clk);
        chk("expiry_pre_out_valid", out_valid, 0);
        @(negedge clk);
        chk("expiry_done_wins_valid", out_valid, 1);
        chk("expiry_done_wins_err", err, 0);
        wait_ready("expiry_block_done");

        // Core never answers: timeout, block discarded.
        lat = -1;
        send_bytes(P4, 0, 16);
        repeat (64) @(negedge clk);
        chk("timeout_err_early", err, 0);
        chk("timeout_in_ready_early", in_ready, 0);
        @(negedge clk);
        chk("timeout_err", err, 1);
        chk("timeout_in_ready", in_ready, 1);
        chk("timeout_out_valid", out_valid, 0);

        // Next block after a timeout is fresh; err stays set.
        lat = 5;
        expect_blk(P5, K2);
        send_bytes(P5, 0, 16);
        @(negedge clk);
        wait_ready("post_timeout_block_done");
        chk("err_sticky", err, 1);
        chk("blk_count_after_four", blk_count, 4);

        // Reset while waiting on the core.
        lat = -1;
        send_bytes(P6, 0, 16);
        repeat (10) @(negedge clk);
        chk("midwait_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_aes_plaintext", aes_plaintext, 0);
        chk("midrst_aes_key", aes_key, 0);
        chk("midrst_aes_start", aes_start, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_blk_count", blk_count, 0);
        chk("midrst_err", err, 0);
        chk("midrst_in_ready", in_ready, 0);
        rst     = 1'b1;
        exp_blk = '0;
        sb_q.delete();
        starts  = start_cnt;
        lat     = 1;
        expect_blk(P7, K2);
        send_bytes(P7, 0, 16);
        @(negedge clk);
        wait_ready("fresh_block_done");
        chk("fresh_single_start", start_cnt - starts, 1);
        chk("fresh_blk_count", blk_count, 1);

        // Stream 4096 blocks through a fast core.
        rst = 1'b0;
        @(negedge clk);
        rst     = 1'b1;
        exp_blk = '0;
        sb_q.delete();
        for (int b = 0; b < 4096; b++) begin
            w  = b;
            pt = {w, ~w, w ^ 32'hc3a50f1e, w + 32'd7};
            expect_blk(pt, K2);
            send_bytes(pt, 0, 16);
            if (b == 4094) begin
                @(negedge clk);
                wait_ready("stream_4095_done");
                chk("blk_count_4095", blk_count, 12'hfff);
            end
        end
        @(negedge clk);
        wait_ready("stream_last_done");
        chk("blk_count_wrap", blk_count, 0);
        chk("stream_err", err, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_stream_feeder.md
AES_STREAM_FEEDER -- requirements
Module: aes_stream_feeder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles spent waiting for aes_done per block.
REQ-002 SHALL have clk  input  1  meaning system clock; all logic is on its rising edge.
REQ-003 SHALL have rst  input  1  meaning reset: one clock, synchronous, active-low (rst=0 resets on the clk rising edge).
REQ-004 SHALL have in_data  input  8  meaning plaintext byte stream (pixel or character bytes).
REQ-005 SHALL have in_valid  input  1  and  in_ready  output  1  meaning the byte handshake.
REQ-006 SHALL have key_in  input  128  meaning the cipher key, held stable by the system.
REQ-007 SHALL have aes_plaintext  output  128  and  aes_key  output  128  meaning the core operands.
REQ-008 SHALL have aes_start  output  1  meaning a one-cycle request to the encryption core.
REQ-009 SHALL have aes_done  input  1  and  aes_ciphertext  input  128  meaning the core completion pulse and its result.
REQ-010 SHALL have out_data  output  128,  out_valid  output  1,  out_ready  input  1  meaning the ciphertext block handshake.
REQ-011 SHALL have blk_count  output  12  meaning the number of blocks delivered, modulo 4096.
REQ-012 SHALL have err  output  1  meaning a sticky timeout flag.

Function
REQ-013 SHALL implement the states FILL, ISSUE, WAIT and HOLD.
REQ-014 in_ready SHALL be 1 only in FILL; a byte is accepted when in_valid and in_ready are both 1.
REQ-015 The first accepted byte of a block SHALL land in plaintext[127:120] and byte k SHALL land in plaintext[127-8k -: 8] (byte 0 = MSB).
REQ-016 A 4-bit byte counter SHALL increment on each accept; on the 16th accept the counter SHALL wrap to 0 and the state SHALL go FILL->ISSUE.
REQ-017 In ISSUE, aes_start SHALL be 1 for exactly one cycle, then the state SHALL go to WAIT.
REQ-018 aes_plaintext and aes_key SHALL be registered, SHALL be valid from ISSUE, and SHALL stay stable through WAIT.
REQ-019 aes_key SHALL capture key_in on the 16th accept.
REQ-020 In WAIT, aes_done=1 SHALL capture aes_ciphertext into out_data and go to HOLD, making out_valid=1 on the next cycle.
REQ-021 In WAIT, a cycle counter SHALL count from 0; when it reaches TIMEOUT-1 without aes_done, err SHALL be set to 1, the block SHALL be discarded, and the state SHALL go to FILL.
REQ-022 If aes_done arrives on the same cycle as the timeout expiry, aes_done SHALL win and err SHALL NOT be set.
REQ-023 aes_done SHALL be ignored outside WAIT.
REQ-024 In HOLD, out_valid=1 and out_data SHALL remain stable until out_ready=1; on that handshake the block SHALL increment blk_count (4095 wraps to 0) and go to FILL.
REQ-025 Throughput SHALL be 16 byte cycles + 1 issue cycle + core latency + 1 or more output cycles per block; no overlap between blocks.

Reset
REQ-026 With rst=0, on the clk edge: state=FILL, byte counter=0, wait counter=0.
REQ-027 With rst=0: aes_plaintext=0, aes_key=0, aes_start=0, out_data=0, out_valid=0, blk_count=0, err=0.
REQ-028 With rst=0, in_ready SHALL be 0; it SHALL become 1 on the first cycle after rst returns to 1.
REQ-029 Reset mid-block (any state) SHALL discard partial bytes and any pending ciphertext; no aes_start or out_valid SHALL follow from the pre-reset block.
REQ-030 err SHALL be cleared only by reset.

Structure
REQ-031 Package aes_pkg SHALL hold the state enum type, AES_BLK_BYTES=16 and AES_BLK_W=128; the package SHALL be shared with the core and the benches.
REQ-032 The byte-to-block shift/pack logic SHALL be one sub-module, aes_byte_packer (inputs: byte, accept strobe, clear; outputs: 128-bit block, full pulse).

Verification
REQ-033 Reset, then feed 49 20 61 6d 20 61 20 70 6c 61 69 6e 74 65 78 74 -> aes_plaintext=4920616d206120706c61696e74657874 and a single aes_start pulse on the cycle after the 16th accept.
REQ-034 Core model returns done after 30 cycles with ciphertext C; hold out_ready=0 for 5 cycles -> out_valid=1 and out_data=C stable for those cycles, in_ready=0 throughout, blk_count 0->1 on the handshake.
REQ-035 Core model never asserts done, TIMEOUT=64 -> err=1 exactly 64 cycles after aes_start falls, in_ready=1 on the next cycle, out_valid never asserted.
REQ-036 aes_done asserted on the timeout-expiry cycle -> HOLD entered, err stays 0; a spurious aes_done in FILL -> no state change.
REQ-037 rst=0 pulsed in WAIT after 10 cycles -> all outputs zero on the next edge, and the next 16 bytes form a fresh block.
REQ-038 Stream 4096 blocks -> blk_count reads 4095 then wraps to 0, with no err.
